// File: rtl/interp_col_buffer_pkg.sv
// Shared constants and state encoding for the interpolation column transpose buffer.
package interp_col_buffer_pkg;

  localparam int SAMPLE_W  = 9;
  localparam int N_SAMPLES = 11;
  localparam int N_LINES   = 11;
  localparam int DATA_W    = SAMPLE_W * N_SAMPLES;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interp_col_buffer_col_select.sv
// Per-row N_SAMPLES:1 sample selector: gathers column sel of the stored block, row 0 in the LSBs.
module interp_col_select #(
  parameter int SAMPLE_W  = interp_col_buffer_pkg::SAMPLE_W,
  parameter int N_SAMPLES = interp_col_buffer_pkg::N_SAMPLES,
  parameter int N_LINES   = interp_col_buffer_pkg::N_LINES,
  parameter int SEL_W     = interp_col_buffer_pkg::cnt_width(N_SAMPLES),
  localparam int DATA_W   = SAMPLE_W * N_SAMPLES
) (
  input  logic [DATA_W-1:0] rows [N_LINES],
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] col
);

  genvar gi;
  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_row
      logic [SAMPLE_W-1:0] pick;

      // Explicit compare chain so an out-of-range select yields zero rather than X.
      always_comb begin
        pick = '0;
        for (int si = 0; si < N_SAMPLES; si++) begin
          if (sel == SEL_W'(si)) begin
            pick = rows[gi][si*SAMPLE_W +: SAMPLE_W];
          end
        end
      end

      assign col[gi*SAMPLE_W +: SAMPLE_W] = pick;
    end
  endgenerate

endmodule

// File: rtl/interp_col_buffer.sv
// Single-bank transpose buffer: collects N_LINES lines, then returns them column by column.
module interp_col_buffer #(
  parameter int SAMPLE_W  = interp_col_buffer_pkg::SAMPLE_W,
  parameter int N_SAMPLES = interp_col_buffer_pkg::N_SAMPLES,
  parameter int N_LINES   = interp_col_buffer_pkg::N_LINES,
  localparam int DATA_W   = SAMPLE_W * N_SAMPLES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] LINE_IN,
  input  logic              LINE_VALID,
  output logic              LINE_READY,
  output logic [DATA_W-1:0] COL_OUT,
  output logic              COL_VALID,
  input  logic              COL_READY,
  output logic              COL_LAST
);

  import interp_col_buffer_pkg::*;

  localparam int WR_W = cnt_width(N_LINES);
  localparam int RD_W = cnt_width(N_SAMPLES);

  state_t            state_reg, state_next;
  logic [WR_W-1:0]   wr_cnt_reg, wr_cnt_next;
  logic [RD_W-1:0]   rd_cnt_reg, rd_cnt_next;
  logic              line_ready_reg;
  logic              col_valid_reg;
  logic              wr_en;
  logic              last_col;
  logic [DATA_W-1:0] rows_reg [N_LINES];
  logic [DATA_W-1:0] col_sel;

  assign last_col = (rd_cnt_reg == RD_W'(N_SAMPLES - 1));

  always_comb begin
    state_next  = state_reg;
    wr_cnt_next = wr_cnt_reg;
    rd_cnt_next = rd_cnt_reg;
    wr_en       = 1'b0;
    case (state_reg)
      FILL: begin
        if (LINE_VALID && line_ready_reg) begin
          wr_en = 1'b1;
          if (wr_cnt_reg == WR_W'(N_LINES - 1)) begin
            wr_cnt_next = '0;
            rd_cnt_next = '0;
            state_next  = DRAIN;
          end else begin
            wr_cnt_next = wr_cnt_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (col_valid_reg && COL_READY) begin
          if (last_col) begin
            rd_cnt_next = '0;
            state_next  = FILL;
          end else begin
            rd_cnt_next = rd_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Handshake flags follow the next state so they are registered, and LINE_READY
  // stays low for the first edge after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= FILL;
      wr_cnt_reg     <= '0;
      rd_cnt_reg     <= '0;
      line_ready_reg <= 1'b0;
      col_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_cnt_reg     <= wr_cnt_next;
      rd_cnt_reg     <= rd_cnt_next;
      line_ready_reg <= (state_next == FILL);
      col_valid_reg  <= (state_next == DRAIN);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_store
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rows_reg[gi] <= '0;
        end else if (wr_en && (wr_cnt_reg == WR_W'(gi))) begin
          rows_reg[gi] <= LINE_IN;
        end
      end
    end
  endgenerate

  interp_col_select #(
    .SAMPLE_W  (SAMPLE_W),
    .N_SAMPLES (N_SAMPLES),
    .N_LINES   (N_LINES),
    .SEL_W     (RD_W)
  ) u_col_select (
    .rows (rows_reg),
    .sel  (rd_cnt_reg),
    .col  (col_sel)
  );

  assign LINE_READY = line_ready_reg;
  assign COL_VALID  = col_valid_reg;
  assign COL_OUT    = col_valid_reg ? col_sel : '0;
  assign COL_LAST   = col_valid_reg & last_col;

endmodule
